// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with fill count, almost flags,
// read-valid strobe, synchronous flush and optional sticky error capture.
// Optional feature macro: FIFO_SYNC_PARAM_ERR_EN (enables overflow/underflow capture).
module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_TH      = 6,
    parameter int unsigned AE_TH      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      valid_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic                      overflow_err,
    output logic                      underflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ae_q, ae_d;
    logic                  af_q, af_d;
    logic                  push, pop;

    // Accept decisions are made on pre-edge flags; flush suppresses both.
    assign push = wr_en & ~full_q & ~clr;
    assign pop  = rd_en & ~empty_q & ~clr;

    // Next-state for pointers, occupancy, read data and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem[rd_ptr_q];
                valid_d  = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        ae_d    = (count_d <= CW'(AE_TH));
        af_d    = (count_d >= CW'(AF_TH));
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_SYNC_PARAM_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error capture; cleared only by reset.
    always_comb begin
        ovf_d = ovf_q | (wr_en & full_q & ~clr);
        unf_d = unf_q | (rd_en & empty_q & ~clr);
    end

    // Error flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    assign data_out     = dout_q;
    assign valid_out    = valid_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for fifo_sync_param,
// default configuration plus a 32x16 instance with different thresholds.
`timescale 1ns/1ps
module tb_fifo_sync_param;

`ifdef FIFO_SYNC_PARAM_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: default parameters
    logic        a_reset, a_clr, a_wr, a_rd;
    logic [9:0]  a_din, a_dout;
    logic [3:0]  a_count;
    logic        a_valid, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;

    fifo_sync_param dut_a (
        .clk(clk), .reset(a_reset), .clr(a_clr), .data_in(a_din),
        .wr_en(a_wr), .rd_en(a_rd), .data_out(a_dout), .valid_out(a_valid),
        .count(a_count), .empty(a_empty), .full(a_full),
        .almost_empty(a_ae), .almost_full(a_af),
        .overflow_err(a_ovf), .underflow_err(a_unf)
    );

    // Instance B: wide and deep
    logic        b_reset, b_clr, b_wr, b_rd;
    logic [31:0] b_din, b_dout;
    logic [4:0]  b_count;
    logic        b_valid, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;

    fifo_sync_param #(.DATA_WIDTH(32), .DEPTH(16), .AF_TH(12), .AE_TH(3)) dut_b (
        .clk(clk), .reset(b_reset), .clr(b_clr), .data_in(b_din),
        .wr_en(b_wr), .rd_en(b_rd), .data_out(b_dout), .valid_out(b_valid),
        .count(b_count), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af),
        .overflow_err(b_ovf), .underflow_err(b_unf)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    endtask

    task automatic a_push(input logic [9:0] d);
        a_wr = 1'b1; a_rd = 1'b0; a_din = d;
        tick();
        a_wr = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
        b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        #23;
        // Reset values
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_empty", 64'(a_empty), 64'd1);
        check("rst_ae",    64'(a_ae),    64'd1);
        check("rst_full",  64'(a_full),  64'd0);
        check("rst_af",    64'(a_af),    64'd0);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_dout",  64'(a_dout),  64'd0);
        check("rst_ovf",   64'(a_ovf),   64'd0);
        check("rst_unf",   64'(a_unf),   64'd0);
        a_reset = 1'b0; b_reset = 1'b0;
        tick();

        // Fill 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1'b1; a_din = 10'(i);
            tick();
            check("fill_count", 64'(a_count), 64'(i));
            check("fill_af",    64'(a_af),    64'(i >= 6));
            check("fill_ae",    64'(a_ae),    64'(i <= 2));
            check("fill_full",  64'(a_full),  64'(i == 8));
            check("fill_empty", 64'(a_empty), 64'd0);
        end
        a_din = 10'h3FF;
        tick();
        a_wr = 1'b0;
        check("ovf_count", 64'(a_count), 64'd8);
        check("ovf_err",   64'(a_ovf),   64'(ERR_EXP));
        check("ovf_unf",   64'(a_unf),   64'd0);

        // Drain
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1'b1;
            tick();
            check("drain_data",  64'(a_dout),  64'(i));
            check("drain_valid", 64'(a_valid), 64'd1);
            check("drain_count", 64'(a_count), 64'(8 - i));
            check("drain_ae",    64'(a_ae),    64'((8 - i) <= 2));
            check("drain_af",    64'(a_af),    64'((8 - i) >= 6));
            check("drain_empty", 64'(a_empty), 64'(i == 8));
        end
        tick();
        a_rd = 1'b0;
        check("unf_valid", 64'(a_valid), 64'd0);
        check("unf_dout",  64'(a_dout),  64'h008);
        check("unf_err",   64'(a_unf),   64'(ERR_EXP));
        tick();
        check("idle_valid", 64'(a_valid), 64'd0);

        // Simultaneous push/pop at count 4, pointers wrap
        for (int i = 0; i < 4; i++) a_push(10'(16'h10 + i));
        check("sim_pre_count", 64'(a_count), 64'd4);
        for (int k = 0; k < 12; k++) begin
            a_wr = 1'b1; a_rd = 1'b1; a_din = 10'(16'h14 + k);
            tick();
            check("sim_count", 64'(a_count), 64'd4);
            check("sim_data",  64'(a_dout),  64'(16'h10 + k));
            check("sim_valid", 64'(a_valid), 64'd1);
        end
        a_idle();
        for (int i = 0; i < 4; i++) a_push(10'(16'h20 + i));
        check("sim_full", 64'(a_full), 64'd1);
        // Push+pop at full: pop only
        a_wr = 1'b1; a_rd = 1'b1; a_din = 10'h3AA;
        tick();
        a_idle();
        check("full_pp_count", 64'(a_count), 64'd7);
        check("full_pp_data",  64'(a_dout),  64'h01C);
        check("full_pp_full",  64'(a_full),  64'd0);
        for (int i = 0; i < 7; i++) begin
            a_rd = 1'b1;
            tick();
            check("full_pp_drain", 64'(a_dout), 64'((i < 3) ? (16'h1D + i) : (16'h20 + i - 3)));
        end
        a_idle();
        check("full_pp_empty", 64'(a_empty), 64'd1);
        // Push+pop at empty: push only, no fall-through
        a_wr = 1'b1; a_rd = 1'b1; a_din = 10'h077;
        tick();
        a_idle();
        check("empty_pp_count", 64'(a_count), 64'd1);
        check("empty_pp_valid", 64'(a_valid), 64'd0);
        check("empty_pp_dout",  64'(a_dout),  64'h023);
        a_rd = 1'b1;
        tick();
        a_idle();
        check("empty_pp_pop", 64'(a_dout), 64'h077);

        // Flush with concurrent push
        for (int i = 0; i < 5; i++) a_push(10'(16'h50 + i));
        check("flush_pre", 64'(a_count), 64'd5);
        a_clr = 1'b1; a_wr = 1'b1; a_din = 10'h099;
        tick();
        a_idle();
        check("flush_count", 64'(a_count), 64'd0);
        check("flush_empty", 64'(a_empty), 64'd1);
        check("flush_ae",    64'(a_ae),    64'd1);
        check("flush_valid", 64'(a_valid), 64'd0);
        a_rd = 1'b1;
        tick();
        a_idle();
        check("flush_pop_valid", 64'(a_valid), 64'd0);
        check("flush_pop_dout",  64'(a_dout),  64'h077);
        check("flush_pop_count", 64'(a_count), 64'd0);
        check("flush_ovf",       64'(a_ovf),   64'(ERR_EXP));

        // Reset mid-clock with a pop in flight
        a_push(10'h101);
        a_push(10'h102);
        a_rd = 1'b1;
        #3 a_reset = 1'b1;
        #1;
        check("mrst_count", 64'(a_count), 64'd0);
        check("mrst_empty", 64'(a_empty), 64'd1);
        check("mrst_dout",  64'(a_dout),  64'd0);
        check("mrst_ovf",   64'(a_ovf),   64'd0);
        check("mrst_unf",   64'(a_unf),   64'd0);
        tick();
        check("mrst_valid", 64'(a_valid), 64'd0);
        a_idle();
        a_reset = 1'b0;
        tick();

        // Instance B: 32x16, thresholds 12 and 3
        for (int i = 1; i <= 16; i++) begin
            b_wr = 1'b1; b_din = 32'hA500_0000 + 32'(i * 32'h0101_0101);
            tick();
            check("b_fill_count", 64'(b_count), 64'(i));
            check("b_fill_af",    64'(b_af),    64'(i >= 12));
            check("b_fill_ae",    64'(b_ae),    64'(i <= 3));
            check("b_fill_full",  64'(b_full),  64'(i == 16));
        end
        b_wr = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            b_rd = 1'b1;
            tick();
            check("b_drain_data",  64'(b_dout),  64'(32'hA500_0000 + 32'(i * 32'h0101_0101)));
            check("b_drain_valid", 64'(b_valid), 64'd1);
            check("b_drain_af",    64'(b_af),    64'((16 - i) >= 12));
            check("b_drain_ae",    64'(b_ae),    64'((16 - i) <= 3));
            check("b_drain_empty", 64'(b_empty), 64'(i == 16));
        end
        b_rd = 1'b0;
        tick();
        check("b_idle_valid", 64'(b_valid), 64'd0);
        check("b_ovf",        64'(b_ovf),   64'd0);
        check("b_unf",        64'(b_unf),   64'd0);
        check("b_clr_idle",   64'(b_clr),   64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
